// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet codes, legal read lengths, transmitter state.
// Imported by both the packet decoder and the response transmitter.
package noc_pkg;

  localparam logic [2:0] PKT_IDLE       = 3'b000;
  localparam logic [2:0] PKT_READ       = 3'b001;
  localparam logic [2:0] PKT_READ_RESP  = 3'b010;
  localparam logic [2:0] PKT_WRITE      = 3'b011;
  localparam logic [2:0] PKT_WRITE_RESP = 3'b100;
  localparam logic [2:0] PKT_RESERVED   = 3'b101;
  localparam logic [2:0] PKT_MESSAGE    = 3'b110;
  localparam logic [2:0] PKT_END        = 3'b111;

  localparam logic [7:0] LEN_1W = 8'h04;
  localparam logic [7:0] LEN_2W = 8'h08;
  localparam logic [7:0] LEN_3W = 8'h0C;

  typedef enum logic [2:0] {
    TX_IDLE, TX_HDR, TX_DEST, TX_LEN, TX_DATA, TX_END
  } tx_state_e;

  typedef struct packed {
    logic       kind;
    logic [7:0] dest;
    logic [7:0] len;
    logic [7:0] status;
  } tx_hdr_t;

  function automatic logic len_legal(input logic [7:0] len);
    return (len == LEN_1W) || (len == LEN_2W) || (len == LEN_3W);
  endfunction

  function automatic logic [7:0] code_byte(input logic [2:0] code);
    return {code, 5'b0};
  endfunction

endpackage

// File: rtl/noc_word_serializer.sv
// Turns fetched 32-bit words into a gapless LSB-first byte stream. A next-word
// buffer takes the following word while the current one is still shifting out.
module noc_word_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic [31:0] cap_data,
  input  logic        load,
  input  logic        shift,
  output logic [7:0]  byte_nxt,
  output logic        last_byte,
  output logic        fetch_slot
);

  logic [31:0] sh_q, nb_q;
  logic [1:0]  bidx_q;

  // sh_q holds only the bytes not yet emitted; byte 0 goes straight from nb_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q   <= '0;
      nb_q   <= '0;
      bidx_q <= '0;
    end else begin
      if (cap) nb_q <= cap_data;
      if (load) begin
        sh_q   <= {8'h00, nb_q[31:8]};
        bidx_q <= 2'd0;
      end else if (shift) begin
        sh_q   <= {8'h00, sh_q[31:8]};
        bidx_q <= bidx_q + 2'd1;
      end
    end
  end

  assign byte_nxt   = load ? nb_q[7:0] : sh_q[7:0];
  assign last_byte  = (bidx_q == 2'd3);
  // Next byte out is index 1: the slot where the following word is fetched.
  assign fetch_slot = shift && (bidx_q == 2'd0);

endmodule

// File: rtl/noc_resp_tx.sv
// NoC response transmitter: serializes READ_RESP / WRITE_RESP packets onto
// CmdR/DataR, fetching read data from the CRC register block one word ahead.
module noc_resp_tx
  import noc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_kind,
  input  logic [7:0]  req_dest_id,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [7:0]  req_status,
  output logic [31:0] crc_addr,
  output logic        crc_sel,
  output logic        crc_rw,
  input  logic [31:0] crc_data_rd,
  output logic        CmdR,
  output logic [7:0]  DataR
);

  tx_state_e   state_q, state_d;
  tx_hdr_t     req_q;
  logic        legal_q, sel_dly_q;
  logic [1:0]  nwords_q, wcnt_q;
  logic [31:0] fetch_addr_q;

  logic        accept, ser_load, ser_shift, ser_last, ser_fetch;
  logic [7:0]  ser_byte;
  logic        cmd_d, sel_d;
  logic [7:0]  data_d;
  logic [31:0] addr_d;

  assign accept    = req_valid && req_ready;
  assign crc_rw    = 1'b0;
  assign ser_shift = (state_q == TX_DATA) && !ser_last;

  always_comb begin
    state_d  = state_q;
    cmd_d    = 1'b1;
    data_d   = code_byte(PKT_IDLE);
    sel_d    = 1'b0;
    addr_d   = crc_addr;
    ser_load = 1'b0;

    case (state_q)
      TX_IDLE: if (accept) state_d = TX_HDR;
      TX_HDR:  state_d = TX_DEST;
      TX_DEST: state_d = TX_LEN;
      TX_LEN:  state_d = (!req_q.kind && legal_q) ? TX_DATA : TX_END;
      TX_DATA: if (ser_last && wcnt_q == nwords_q - 2'd1) state_d = TX_END;
      TX_END:  state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase

    // A word starts on entry to DATA and after every fourth byte.
    ser_load = (state_d == TX_DATA) && (state_q != TX_DATA || ser_last);

    case (state_d)
      TX_HDR:  data_d = code_byte(req_kind ? PKT_WRITE_RESP : PKT_READ_RESP);
      TX_DEST: begin cmd_d = 1'b0; data_d = req_q.dest; end
      TX_LEN:  begin
        cmd_d  = 1'b0;
        data_d = req_q.kind ? req_q.status : (legal_q ? req_q.len : 8'h00);
      end
      TX_DATA: begin cmd_d = 1'b0; data_d = ser_byte; end
      TX_END:  data_d = code_byte(PKT_END);
      default: ;
    endcase

    if (accept && !req_kind && len_legal(req_len)) begin
      sel_d  = 1'b1;
      addr_d = req_addr;
    end else if (ser_fetch && (wcnt_q + 2'd1 < nwords_q)) begin
      sel_d  = 1'b1;
      addr_d = fetch_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= TX_IDLE;
      req_q        <= '0;
      legal_q      <= 1'b0;
      nwords_q     <= '0;
      wcnt_q       <= '0;
      fetch_addr_q <= '0;
      sel_dly_q    <= 1'b0;
      req_ready    <= 1'b0;
      CmdR         <= 1'b1;
      DataR        <= 8'h00;
      crc_sel      <= 1'b0;
      crc_addr     <= '0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == TX_IDLE);
      CmdR      <= cmd_d;
      DataR     <= data_d;
      crc_sel   <= sel_d;
      crc_addr  <= addr_d;
      sel_dly_q <= crc_sel;
      if (accept) begin
        req_q    <= '{kind: req_kind, dest: req_dest_id, len: req_len, status: req_status};
        legal_q  <= len_legal(req_len);
        nwords_q <= req_len[3:2];
      end
      // Address wraps naturally at 2^32.
      if (sel_d) fetch_addr_q <= addr_d + 32'd4;
      if (ser_load) wcnt_q <= (state_q == TX_DATA) ? wcnt_q + 2'd1 : 2'd0;
    end
  end

  noc_word_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .cap       (sel_dly_q),
    .cap_data  (crc_data_rd),
    .load      (ser_load),
    .shift     (ser_shift),
    .byte_nxt  (ser_byte),
    .last_byte (ser_last),
    .fetch_slot(ser_fetch)
  );

endmodule

// File: tb/tb_noc_resp_tx.sv
// Scoreboard bench for noc_resp_tx: stimulus pushes expected bus bytes and CRC
// fetches (with their cycle numbers); a negedge monitor pops and compares.
module tb_noc_resp_tx;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_kind = 1'b0;
  logic [7:0]  req_dest_id = '0, req_len = '0, req_status = '0;
  logic [31:0] req_addr = '0, crc_data_rd = '0;
  logic        req_ready, crc_sel, crc_rw, CmdR;
  logic [31:0] crc_addr;
  logic [7:0]  DataR;

  noc_resp_tx dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_dest_id(req_dest_id), .req_addr(req_addr),
    .req_len(req_len), .req_status(req_status), .crc_addr(crc_addr),
    .crc_sel(crc_sel), .crc_rw(crc_rw), .crc_data_rd(crc_data_rd),
    .CmdR(CmdR), .DataR(DataR)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [8:0]  val;  } ev_t;
  typedef struct { int cyc; logic [31:0] addr; } fe_t;
  ev_t exp_q[$];
  fe_t fet_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int rdy_from = 1 << 30;
  bit mon_en = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // CRC block model: data valid the cycle after crc_sel, junk otherwise.
  always @(posedge clk) begin : rsp
    logic        s;
    logic [31:0] a;
    s = crc_sel;
    a = crc_addr;
    #1 crc_data_rd = s ? mem_rd(a) : $urandom;
  end

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("bus_missed", 32'(exp_q[0].cyc), 32'(cyc));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        chk("bus_byte", {23'd0, CmdR, DataR}, {23'd0, exp_q[0].val});
        void'(exp_q.pop_front());
      end else
        chk("bus_idle", {23'd0, CmdR, DataR}, 32'h100);
      if (fet_q.size() > 0 && fet_q[0].cyc < cyc) begin
        chk("crc_fetch_missed", 32'(fet_q[0].cyc), 32'(cyc));
        void'(fet_q.pop_front());
      end
      if (fet_q.size() > 0 && fet_q[0].cyc == cyc) begin
        chk("crc_sel", {31'd0, crc_sel}, 32'd1);
        chk("crc_addr", crc_addr, fet_q[0].addr);
        void'(fet_q.pop_front());
      end else
        chk("crc_sel_quiet", {31'd0, crc_sel}, 32'd0);
      chk("crc_rw", {31'd0, crc_rw}, 32'd0);
      chk("req_ready", {31'd0, req_ready}, {31'd0, (cyc >= rdy_from)});
    end
  end

  task automatic push_b(input int c, input logic [8:0] v);
    exp_q.push_back('{c, v});
  endtask

  // Issue one request; when b2b, req_valid was held from the previous one.
  task automatic send(input logic kind, input logic [7:0] dest, input logic [31:0] addr,
                      input logic [7:0] len, input logic [7:0] st, input bit hold,
                      input bit b2b, output int acc);
    int t, n;
    logic [31:0] w;
    req_valid = 1'b1; req_kind = kind; req_dest_id = dest;
    req_addr = addr; req_len = len; req_status = st;
    t = 0;
    do begin @(posedge clk); t++; end while (!req_ready && t < 300);
    acc = cyc;
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout cycle=%0d actual=no accept expected=accept", cyc);
      req_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_cycle", 32'(acc), 32'(rdy_from));
    n = (!kind && (len == 8'h04 || len == 8'h08 || len == 8'h0C)) ? int'(len) / 4 : 0;
    push_b(acc + 1, kind ? 9'h180 : 9'h140);
    push_b(acc + 2, {1'b0, dest});
    push_b(acc + 3, {1'b0, kind ? st : (n > 0 ? len : 8'h00)});
    for (int k = 0; k < n; k++) begin
      w = mem_rd(addr + 32'(4 * k));
      fet_q.push_back('{acc + 1 + 4 * k, addr + 32'(4 * k)});
      for (int b = 0; b < 4; b++) push_b(acc + 4 + 4 * k + b, {1'b0, w[8 * b +: 8]});
    end
    push_b(acc + 4 + 4 * n, 9'h1E0);
    rdy_from = acc + 5 + 4 * n;
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() > 0 || cyc < rdy_from) && t < 500) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 500) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout cycle=%0d actual=busy expected=idle", cyc);
    end
  endtask

  initial begin
    int acc;
    bit hold, prev_hold;
    logic [7:0] len;
    logic [31:0] addr;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_CmdR", {31'd0, CmdR}, 32'd1);
    chk("rst_DataR", {24'd0, DataR}, 32'd0);
    chk("rst_crc_sel", {31'd0, crc_sel}, 32'd0);
    chk("rst_crc_addr", crc_addr, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    mon_en = 1'b1;
    rst = 1'b1;
    rdy_from = cyc + 1;

    mem[32'h10] = 32'hDEADBEEF;
    send(1'b0, 8'h05, 32'h10, 8'h04, 8'h00, 1'b0, 1'b0, acc);
    wait_idle();

    mem[32'h20] = 32'h11223344; mem[32'h24] = 32'h55667788; mem[32'h28] = 32'h99AABBCC;
    send(1'b0, 8'h42, 32'h20, 8'h0C, 8'h00, 1'b0, 1'b0, acc);
    wait_idle();

    send(1'b1, 8'h3A, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    wait_idle();
    send(1'b0, 8'h6D, 32'h40, 8'h07, 8'h00, 1'b0, 1'b0, acc);
    wait_idle();
    send(1'b0, 8'h09, 32'hFFFF_FFFC, 8'h08, 8'h00, 1'b0, 1'b0, acc);
    wait_idle();

    // Reset during the second data byte of a two-word read.
    send(1'b0, 8'h11, 32'h100, 8'h08, 8'h00, 1'b0, 1'b0, acc);
    while (cyc < acc + 5) begin @(negedge clk); #1; end
    rst = 1'b0;
    rdy_from = 1 << 30;
    while (exp_q.size() > 0 && exp_q[$].cyc > acc + 5) void'(exp_q.pop_back());
    while (fet_q.size() > 0 && fet_q[$].cyc > acc + 5) void'(fet_q.pop_back());
    @(negedge clk); #1;
    chk("midrst_crc_addr", crc_addr, 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    rdy_from = cyc + 1;
    wait_idle();

    send(1'b0, 8'hA1, 32'h10, 8'h04, 8'h00, 1'b1, 1'b0, acc);
    send(1'b1, 8'hA2, 32'h0, 8'h00, 8'h5C, 1'b0, 1'b1, acc);
    wait_idle();

    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: len = 8'h04;
        1: len = 8'h08;
        2: len = 8'h0C;
        default: len = 8'($urandom);
      endcase
      addr = ($urandom_range(0, 3) == 0) ? {28'hFFFF_FFF, 4'($urandom) & 4'hC} : $urandom;
      hold = ($urandom_range(0, 2) == 0);
      send(1'($urandom_range(0, 2) == 0), 8'($urandom), addr, len, 8'($urandom),
           hold, prev_hold, acc);
      prev_hold = hold;
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_resp_tx.md
# noc_resp_tx

Response transmitter for the NoC link. It accepts completed read/write requests from the packet decoder and fetches read data from the CRC register block over its addr/Sel/RW/data_rd port. It then serializes READ_RESP and WRITE_RESP packets onto the outbound byte bus (CmdR/DataR). It sits between the decoder/CRC pair and the NoC return path.

## Interface
- No parameters. The fixed widths are an 8-bit bus, a 32-bit address and a 32-bit word.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- req_valid  in  1  request pending
- req_ready  out  1  block can accept a request (IDLE only)
- req_kind  in  1  0 = read response, 1 = write response
- req_dest_id  in  8  requester SourceID, copied into the packet
- req_addr  in  32  read base address
- req_len  in  8  read byte count: 8'h04, 8'h08 or 8'h0C
- req_status  in  8  write status byte (8'h00 = OK)
- crc_addr  out  32  CRC word address
- crc_sel  out  1  CRC select, one-cycle pulse per word
- crc_rw  out  1  CRC direction; tied to 0 (read only)
- crc_data_rd  in  32  CRC read data, valid the cycle after crc_sel
- CmdR  out  1  1 = framing/header byte
- DataR  out  8  outbound byte

## Operation
- **Packet codes** occupy DataR[7:5] on CmdR=1 bytes; DataR[4:0] = 0.
  - IDLE 000, READ_RESP 010, WRITE_RESP 100, END 111.
  - Idle bus = CmdR=1, DataR=8'h00.
- **Accept:** a request is accepted on the edge where req_valid && req_ready. All req_* fields are registered at that edge. req_valid during a busy packet is ignored; the producer holds it.
- **READ_RESP packet**, in order:
  - header 8'h40 (CmdR=1)
  - dest ID (CmdR=0)
  - length byte (CmdR=0)
  - 4·n data bytes, each word LSB first (CmdR=0)
  - END 8'hE0 (CmdR=1)
  - n = req_len/4.
- **Illegal req_len** (anything other than 04/08/0C): the length byte is 8'h00, no data bytes are sent, no crc_sel is issued, and END follows directly.
- **WRITE_RESP packet:** header 8'h80, dest ID, req_status, END.
- **Addressing:** word k is read from req_addr + 4k, modulo 2^32 (wraps at the top of memory).
- **State machine:** IDLE → HDR → DEST → LEN/STAT → DATA (byte counter 0..3, word counter 0..n-1; read only) → END → IDLE.
- **Reset:** rst=0 in any state forces IDLE on that edge. Any partial packet is dropped with no END sent.
- **Reset values:**
  - CmdR=1, DataR=8'h00
  - crc_sel=0, crc_rw=0, crc_addr=32'h0
  - req_ready=0
  - All internal buffers cleared.
- **After reset release:** req_ready rises one cycle later and is high throughout IDLE.

## Timing
- Outputs are registered. Cycle 1 is the first cycle after the accept edge.
- **Read timeline:**
  - Cycle 1: header; crc_sel=1 with crc_addr=base (fetch of word 0).
  - Cycle 2: dest; crc_data_rd is captured at the end of this cycle.
  - Cycle 3: length byte.
  - Word k occupies cycles 4+4k .. 7+4k.
  - Fetch of word k (k≥1) is issued in cycle 4k+1 (byte 1 of word k-1) and captured at the end of cycle 4k+2 into a next-word buffer.
  - The data stream has no gaps.
  - END is in cycle 4+4n; req_ready=1 again in cycle 5+4n.
  - Packet lengths are 8/12/16 bytes for n=1/2/3.
- **Write:** header in cycle 1, dest 2, status 3, END 4, req_ready in cycle 5.
- **crc_sel:** exactly one cycle high per fetched word; crc_addr is held stable in that cycle; crc_rw is always 0.
- **Back-to-back requests:** header of the next packet is no earlier than one cycle after END; at least one idle byte separates packets.

## Structure
- **Shared package `noc_pkg`:**
  - 3-bit packet code constants (IDLE, READ, READ_RESP, WRITE, WRITE_RESP, RESERVED, MESSAGE, END)
  - length encodings 8'h04/8'h08/8'h0C
  - transmitter state enum
  - The decoder imports the same package.
- **Sub-module `noc_word_serializer`:**
  - 32-bit shift register plus next-word buffer
  - load/shift controls
  - emits bytes LSB first
  - flags byte index 1 for fetch scheduling

## Test plan
- **Read, n=1:** req_len=04, addr=32'h0000_0010, dest=8'h05, crc returns 32'hDEADBEEF → bus 40,05,04,EF,BE,AD,DE,E0; single crc_sel in cycle 1 with addr 0x10; req_ready back in cycle 9.
- **Read, n=3:** req_len=0C, addr=32'h20, words 11223344/55667788/99AABBCC → crc_sel in cycles 1, 5, 9 with addrs 20/24/28; 12 contiguous data bytes 44,33,22,11,88,…,99; END in cycle 16.
- **Write response:** req_kind=1, dest=8'h3A, status=8'h00 → 80,3A,00,E0; crc_sel never asserted.
- **Boundaries:**
  - req_len=8'h07 → 40,dd,00,E0 with no crc_sel.
  - addr=32'hFFFF_FFFC with len 08 → second fetch at 32'h0000_0000.
- **Reset mid-packet:** rst=0 during the second data byte → next cycle CmdR=1, DataR=00, crc_sel=0, no END sent; req_ready=1 one cycle after rst returns to 1.
- **Back-to-back:** req_valid held high across two requests → the second is accepted only in IDLE, with one idle byte between END and the next header.
